// File: rtl/decode_pkg.sv
// Shared decode definitions: control word layout, ALU/MD encodings, opcodes.
// The MD field is only populated by builds with DECODE_MULDIV_EN.
package decode_pkg;

    typedef struct packed {
        logic [2:0] md;
        logic       memsgn;
        logic [1:0] memsz;
        logic       rwd;
        logic       rwe;
        logic       dmwe;
        logic [3:0] aluop;
        logic       alusrc;
        logic       link;
        logic       jr;
        logic       jp;
        logic       br;
    } ctrl_t;

    localparam int CTRL_W      = $bits(ctrl_t);
    localparam int CTRL_BR     = 0;
    localparam int CTRL_JP     = 1;
    localparam int CTRL_JR     = 2;
    localparam int CTRL_LINK   = 3;
    localparam int CTRL_ALUSRC = 4;
    localparam int CTRL_ALUOP  = 5;
    localparam int CTRL_DMWE   = 9;
    localparam int CTRL_RWE    = 10;
    localparam int CTRL_RWD    = 11;
    localparam int CTRL_MEMSZ  = 12;
    localparam int CTRL_MEMSGN = 14;
    localparam int CTRL_MD     = 15;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    // With BR=1 the ALUOP field selects the branch condition
    localparam logic [3:0] BR_EQ  = 4'd0;
    localparam logic [3:0] BR_NE  = 4'd1;
    localparam logic [3:0] BR_LEZ = 4'd2;
    localparam logic [3:0] BR_GTZ = 4'd3;
    localparam logic [3:0] BR_LTZ = 4'd4;
    localparam logic [3:0] BR_GEZ = 4'd5;

    // With MD=MF/MT, ALUOP[0] selects HI (0) or LO (1)
    localparam logic [3:0] HILO_LO = 4'd1;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MUL   = 3'd1;
    localparam logic [2:0] MD_MULT  = 3'd2;
    localparam logic [2:0] MD_MULTU = 3'd3;
    localparam logic [2:0] MD_DIV   = 3'd4;
    localparam logic [2:0] MD_DIVU  = 3'd5;
    localparam logic [2:0] MD_MF    = 3'd6;
    localparam logic [2:0] MD_MT    = 3'd7;

    localparam logic [1:0] MSZ_B = 2'd0;
    localparam logic [1:0] MSZ_W = 2'd2;

    localparam logic [5:0] OP_SPECIAL  = 6'h00;
    localparam logic [5:0] OP_REGIMM   = 6'h01;
    localparam logic [5:0] OP_J        = 6'h02;
    localparam logic [5:0] OP_JAL      = 6'h03;
    localparam logic [5:0] OP_BEQ      = 6'h04;
    localparam logic [5:0] OP_BNE      = 6'h05;
    localparam logic [5:0] OP_BLEZ     = 6'h06;
    localparam logic [5:0] OP_BGTZ     = 6'h07;
    localparam logic [5:0] OP_ADDIU    = 6'h09;
    localparam logic [5:0] OP_SLTI     = 6'h0A;
    localparam logic [5:0] OP_SLTIU    = 6'h0B;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [5:0] OP_LUI      = 6'h0F;
    localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
    localparam logic [5:0] OP_LB       = 6'h20;
    localparam logic [5:0] OP_LW       = 6'h23;
    localparam logic [5:0] OP_LBU      = 6'h24;
    localparam logic [5:0] OP_SB       = 6'h28;
    localparam logic [5:0] OP_SW       = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MTHI  = 6'h11;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MTLO  = 6'h13;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;
    localparam logic [5:0] FN_MUL   = 6'h02;

    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef enum logic [2:0] {IMM_SE, IMM_ZE, IMM_LUI, IMM_J, IMM_SH} imm_e;
    typedef enum logic [1:0] {DST_NONE, DST_RD, DST_RT, DST_RA} dst_e;

endpackage

// File: rtl/decode_if.sv
// Instruction-in / bundle-out handshake bus of the decode stage.
// master drives instructions and consumes bundles; slave is the stage.
interface decode_if
    import decode_pkg::*;
#(
    parameter int PC_W = 32
) ();
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_insn;
    logic [PC_W-1:0]   in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_dst;
    logic [31:0]       out_imm;
    logic [PC_W-1:0]   out_pc;
    logic [2:0]        out_flags;

    modport master (
        output in_valid, in_insn, in_pc, out_ready,
        input  in_ready, out_valid, out_ctrl, out_rs, out_rt,
        input  out_dst, out_imm, out_pc, out_flags
    );

    modport slave (
        input  in_valid, in_insn, in_pc, out_ready,
        output in_ready, out_valid, out_ctrl, out_rs, out_rt,
        output out_dst, out_imm, out_pc, out_flags
    );
endinterface

// File: rtl/decode_logic.sv
// Combinational MIPS decoder: control word, register indices, immediate.
// Multiply/divide encodings decode only when DECODE_MULDIV_EN is defined.
module decode_logic
    import decode_pkg::*;
(
    input  logic [31:0] insn,
    input  logic [3:0]  pc_hi,
    output ctrl_t       ctrl,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  dst,
    output logic [31:0] imm,
    output logic        illegal,
    output logic        nop,
    output logic        use_rs,
    output logic        use_rt
);
    logic [5:0] op;
    logic [5:0] fn;
    logic       is_spec;
    logic       is_regimm;
    imm_e       isel;
    dst_e       dsel;

    assign op        = insn[31:26];
    assign fn        = insn[5:0];
    assign rs        = insn[25:21];
    assign rt        = insn[20:16];
    assign nop       = insn == 32'h0;
    assign is_spec   = op == OP_SPECIAL && !nop;
    assign is_regimm = op == OP_REGIMM;
`ifdef DECODE_MULDIV_EN
    logic is_spec2;
    assign is_spec2 = op == OP_SPECIAL2;
`endif

    always_comb begin
        ctrl    = '0;
        illegal = 1'b0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        isel    = IMM_SE;
        dsel    = DST_NONE;
        unique case (1'b1)
            nop: ;
            is_spec: begin
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                dsel     = DST_RD;
                ctrl.rwe = 1'b1;
                case (fn)
                    FN_ADDU: ctrl.aluop = ALU_ADD;
                    FN_SUBU: ctrl.aluop = ALU_SUB;
                    FN_AND:  ctrl.aluop = ALU_AND;
                    FN_OR:   ctrl.aluop = ALU_OR;
                    FN_XOR:  ctrl.aluop = ALU_XOR;
                    FN_NOR:  ctrl.aluop = ALU_NOR;
                    FN_SLT:  ctrl.aluop = ALU_SLT;
                    FN_SLTU: ctrl.aluop = ALU_SLTU;
                    FN_SLL, FN_SRL, FN_SRA: begin
                        ctrl.aluop  = (fn == FN_SLL) ? ALU_SLL :
                                      (fn == FN_SRL) ? ALU_SRL : ALU_SRA;
                        ctrl.alusrc = 1'b1;
                        isel        = IMM_SH;
                        use_rs      = 1'b0;
                    end
                    FN_JR, FN_JALR: begin
                        ctrl.jp   = 1'b1;
                        ctrl.jr   = 1'b1;
                        ctrl.link = fn == FN_JALR;
                        ctrl.rwe  = fn == FN_JALR;
                        use_rt    = 1'b0;
                    end
`ifdef DECODE_MULDIV_EN
                    FN_MULT:  begin ctrl.md = MD_MULT;  ctrl.rwe = 1'b0; end
                    FN_MULTU: begin ctrl.md = MD_MULTU; ctrl.rwe = 1'b0; end
                    FN_DIV:   begin ctrl.md = MD_DIV;   ctrl.rwe = 1'b0; end
                    FN_DIVU:  begin ctrl.md = MD_DIVU;  ctrl.rwe = 1'b0; end
                    FN_MFHI, FN_MFLO: begin
                        ctrl.md    = MD_MF;
                        ctrl.aluop = (fn == FN_MFLO) ? HILO_LO : 4'd0;
                        use_rs     = 1'b0;
                        use_rt     = 1'b0;
                    end
                    FN_MTHI, FN_MTLO: begin
                        ctrl.md    = MD_MT;
                        ctrl.aluop = (fn == FN_MTLO) ? HILO_LO : 4'd0;
                        ctrl.rwe   = 1'b0;
                        use_rt     = 1'b0;
                    end
`endif
                    default: illegal = 1'b1;
                endcase
            end
            is_regimm: begin
                ctrl.br = 1'b1;
                use_rs  = 1'b1;
                case (rt)
                    RT_BLTZ: ctrl.aluop = BR_LTZ;
                    RT_BGEZ: ctrl.aluop = BR_GEZ;
                    default: illegal = 1'b1;
                endcase
            end
`ifdef DECODE_MULDIV_EN
            is_spec2: begin
                ctrl.md  = MD_MUL;
                ctrl.rwe = 1'b1;
                dsel     = DST_RD;
                use_rs   = 1'b1;
                use_rt   = 1'b1;
                illegal  = fn != FN_MUL;
            end
`endif
            default: begin
                use_rs = 1'b1;
                case (op)
                    OP_J, OP_JAL: begin
                        ctrl.jp   = 1'b1;
                        ctrl.link = op == OP_JAL;
                        ctrl.rwe  = op == OP_JAL;
                        dsel      = DST_RA;
                        isel      = IMM_J;
                        use_rs    = 1'b0;
                    end
                    OP_BEQ:  begin ctrl.br = 1'b1; ctrl.aluop = BR_EQ; use_rt = 1'b1; end
                    OP_BNE:  begin ctrl.br = 1'b1; ctrl.aluop = BR_NE; use_rt = 1'b1; end
                    OP_BLEZ: begin ctrl.br = 1'b1; ctrl.aluop = BR_LEZ; end
                    OP_BGTZ: begin ctrl.br = 1'b1; ctrl.aluop = BR_GTZ; end
                    OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                        ctrl.alusrc = 1'b1;
                        ctrl.rwe    = 1'b1;
                        dsel        = DST_RT;
                        case (op)
                            OP_SLTI:  ctrl.aluop = ALU_SLT;
                            OP_SLTIU: ctrl.aluop = ALU_SLTU;
                            OP_ANDI:  begin ctrl.aluop = ALU_AND; isel = IMM_ZE; end
                            OP_ORI:   begin ctrl.aluop = ALU_OR;  isel = IMM_ZE; end
                            OP_XORI:  begin ctrl.aluop = ALU_XOR; isel = IMM_ZE; end
                            OP_LUI: begin
                                ctrl.aluop = ALU_LUI;
                                isel       = IMM_LUI;
                                use_rs     = 1'b0;
                            end
                            default:  ctrl.aluop = ALU_ADD;
                        endcase
                    end
                    OP_LW, OP_LB, OP_LBU: begin
                        ctrl.alusrc = 1'b1;
                        ctrl.rwe    = 1'b1;
                        ctrl.rwd    = 1'b1;
                        ctrl.memsz  = (op == OP_LW) ? MSZ_W : MSZ_B;
                        ctrl.memsgn = op != OP_LBU;
                        dsel        = DST_RT;
                    end
                    OP_SW, OP_SB: begin
                        ctrl.alusrc = 1'b1;
                        ctrl.dmwe   = 1'b1;
                        ctrl.memsz  = (op == OP_SW) ? MSZ_W : MSZ_B;
                        ctrl.memsgn = 1'b1;
                        use_rt      = 1'b1;
                    end
                    default: illegal = 1'b1;
                endcase
            end
        endcase
        if (illegal) begin
            ctrl   = '0;
            use_rs = 1'b0;
            use_rt = 1'b0;
        end
    end

    always_comb begin
        unique case (dsel)
            DST_RD:  dst = insn[15:11];
            DST_RT:  dst = rt;
            DST_RA:  dst = 5'd31;
            default: dst = 5'd0;
        endcase
        if (!ctrl.rwe) dst = 5'd0;
    end

    always_comb begin
        unique case (isel)
            IMM_ZE:  imm = {16'h0, insn[15:0]};
            IMM_LUI: imm = {insn[15:0], 16'h0};
            IMM_J:   imm = {pc_hi, insn[25:0], 2'b00};
            IMM_SH:  imm = {27'h0, insn[10:6]};
            default: imm = {{16{insn[15]}}, insn[15:0]};
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// Decode stage: decoder, DEPTH-entry output queue and load-use bubble insertion.
// DECODE_MULDIV_EN enables multiply/divide decode in decode_logic.
module decode_stage
    import decode_pkg::*;
#(
    parameter int PC_W  = 32,
    parameter int DEPTH = 2
) (
    input logic     clk,
    input logic     rst_n,
    input logic     flush,
    decode_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        ctrl_t           ctrl;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      dst;
        logic [31:0]     imm;
        logic [PC_W-1:0] pc;
        logic [2:0]      flags;
    } entry_t;

    ctrl_t       d_ctrl;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [4:0]  d_dst;
    logic [31:0] d_imm;
    logic        d_ill;
    logic        d_nop;
    logic        d_urs;
    logic        d_urt;
    logic [3:0]  pc_hi;

    if (PC_W >= 32) begin : g_pc_hi
        assign pc_hi = bus.in_pc[31:28];
    end else begin : g_pc_lo
        assign pc_hi = 4'h0;
    end

    decode_logic u_dec (
        .insn    (bus.in_insn),
        .pc_hi   (pc_hi),
        .ctrl    (d_ctrl),
        .rs      (d_rs),
        .rt      (d_rt),
        .dst     (d_dst),
        .imm     (d_imm),
        .illegal (d_ill),
        .nop     (d_nop),
        .use_rs  (d_urs),
        .use_rt  (d_urt)
    );

    entry_t        q [DEPTH];
    entry_t        wr;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW:0]   count;
    logic [4:0]    last_load;
    logic          en;
    logic          full;
    logic          hazard;
    logic          push_insn;
    logic          push_bub;
    logic          push;
    logic          pop;

    assign full   = count == (AW+1)'(DEPTH);
    assign hazard = bus.in_valid && last_load != 5'd0 &&
                    ((d_urs && d_rs == last_load) ||
                     (d_urt && d_rt == last_load));

    // flush wins over any push, so the input is refused during it
    assign bus.in_ready = en && !flush && !full && !hazard;
    assign push_insn    = bus.in_valid && bus.in_ready;
    assign push_bub     = en && !flush && !full && hazard;
    assign push         = push_insn || push_bub;
    assign pop          = bus.out_valid && bus.out_ready && !flush;

    always_comb begin
        wr    = '0;
        wr.pc = bus.in_pc;
        if (push_bub) begin
            wr.flags = 3'b001;
        end else begin
            wr.ctrl  = d_ctrl;
            wr.rs    = d_rs;
            wr.rt    = d_rt;
            wr.dst   = d_dst;
            wr.imm   = d_imm;
            wr.flags = {d_ill, d_nop, 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en        <= 1'b0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            last_load <= '0;
        end else begin
            en <= 1'b1;
            if (flush) begin
                head      <= '0;
                tail      <= '0;
                count     <= '0;
                last_load <= '0;
            end else begin
                if (push) begin
                    tail      <= tail + 1'b1;
                    last_load <= (push_insn && d_ctrl.rwd) ? d_dst : 5'd0;
                end
                if (pop) head <= head + 1'b1;
                if (push && !pop) count <= count + 1'b1;
                else if (pop && !push) count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) q[tail] <= wr;
    end

    assign bus.out_valid = count != '0;
    assign bus.out_ctrl  = q[head].ctrl;
    assign bus.out_rs    = q[head].rs;
    assign bus.out_rt    = q[head].rt;
    assign bus.out_dst   = q[head].dst;
    assign bus.out_imm   = q[head].imm;
    assign bus.out_pc    = q[head].pc;
    assign bus.out_flags = q[head].flags;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage (DEPTH=2).
// MUL expectations follow DECODE_MULDIV_EN.
module tb_decode_stage;
    import decode_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_tests = 0;
    int   n_fail = 0;

    decode_if #(.PC_W(32)) bus ();

    decode_stage #(.PC_W(32), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] insn,
                         input logic [31:0] pc);
        bus.in_valid = v;
        bus.in_insn  = insn;
        bus.in_pc    = pc;
    endtask

    localparam int NV = 10;
    logic [31:0] v_insn [NV] = '{32'hFC000000, 32'h00000000, 32'h08000040,
                                 32'h0C000040, 32'h3402FFFF, 32'h2402FFFF,
                                 32'h3C021234, 32'hAC820004, 32'h1082FFFF,
                                 32'h00021080};
    logic [31:0] v_imm [NV]  = '{32'h0, 32'h0, 32'h100, 32'h100, 32'h0000FFFF,
                                 32'hFFFFFFFF, 32'h12340000, 32'h4,
                                 32'hFFFFFFFF, 32'h2};
    logic [4:0]  v_dst [NV]  = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd2, 5'd2, 5'd2,
                                 5'd0, 5'd0, 5'd2};
    logic [2:0]  v_flg [NV]  = '{3'b100, 3'b010, 3'b000, 3'b000, 3'b000,
                                 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};

    logic [2:0] mul_flags;
    logic       mul_md_nz;
    logic [4:0] mul_dst;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
`ifdef DECODE_MULDIV_EN
        mul_flags = 3'b000; mul_md_nz = 1'b1; mul_dst = 5'd2;
`else
        mul_flags = 3'b100; mul_md_nz = 1'b0; mul_dst = 5'd0;
`endif
        drive(1'b0, 32'h0, 32'h0);
        bus.out_ready = 1'b1;

        // reset
        #2;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_in_ready", bus.in_ready, 0);
        #6 rst_n = 1'b1;
        #4;
        check("rel_in_ready_pre_edge", bus.in_ready, 0);
        tick();
        check("rel_in_ready", bus.in_ready, 1);
        check("rel_out_valid", bus.out_valid, 0);

        // ADDU, latency 1
        drive(1'b1, 32'h00851021, 32'h100);
        #1 check("addu_in_ready", bus.in_ready, 1);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("addu_valid", bus.out_valid, 1);
        check("addu_rwe", bus.out_ctrl[CTRL_RWE], 1);
        check("addu_dst", bus.out_dst, 2);
        check("addu_rs", bus.out_rs, 4);
        check("addu_rt", bus.out_rt, 5);
        check("addu_pc", bus.out_pc, 32'h100);
        check("addu_flags", bus.out_flags, 0);
        tick();
        check("addu_drained", bus.out_valid, 0);

        // load-use hazard
        drive(1'b1, 32'h8C820004, 32'h200);
        tick();
        drive(1'b1, 32'h00451821, 32'h204);
        #1;
        check("hz_in_ready", bus.in_ready, 0);
        check("hz_lw_rwd", bus.out_ctrl[CTRL_RWD], 1);
        check("hz_lw_dst", bus.out_dst, 2);
        check("hz_lw_imm", bus.out_imm, 4);
        tick();
        check("hz_ready_back", bus.in_ready, 1);
        check("hz_bub_flags", bus.out_flags, 3'b001);
        check("hz_bub_ctrl", bus.out_ctrl, 0);
        check("hz_bub_pc", bus.out_pc, 32'h204);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("hz_addu_valid", bus.out_valid, 1);
        check("hz_addu_flags", bus.out_flags, 0);
        check("hz_addu_dst", bus.out_dst, 3);
        check("hz_addu_rs", bus.out_rs, 2);
        check("hz_addu_pc", bus.out_pc, 32'h204);
        tick();
        check("hz_drained", bus.out_valid, 0);

        // backpressure, DEPTH=2
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00851021, 32'h300);
        tick();
        drive(1'b1, 32'h00851021, 32'h304);
        #1 check("bp_ready_1", bus.in_ready, 1);
        tick();
        drive(1'b1, 32'h00851021, 32'h308);
        #1 check("bp_full", bus.in_ready, 0);
        tick();
        check("bp_still_full", bus.in_ready, 0);
        check("bp_hold_pc", bus.out_pc, 32'h300);
        bus.out_ready = 1'b1;
        #1 check("bp_pop_cycle", bus.in_ready, 0);
        tick();
        bus.out_ready = 1'b0;
        #1 check("bp_ready_after_pop", bus.in_ready, 1);
        check("bp_head_b", bus.out_pc, 32'h304);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("bp_c_held_b", bus.out_pc, 32'h304);
        check("bp_full_again", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        tick();
        check("bp_head_c", bus.out_pc, 32'h308);
        tick();
        check("bp_drained", bus.out_valid, 0);

        // decode vectors
        for (int i = 0; i < NV; i++) begin
            drive(1'b1, v_insn[i], 32'h400);
            tick();
            drive(1'b0, 32'h0, 32'h0);
            check($sformatf("v%0d_valid", i), bus.out_valid, 1);
            check($sformatf("v%0d_imm", i), bus.out_imm, v_imm[i]);
            check($sformatf("v%0d_dst", i), bus.out_dst, v_dst[i]);
            check($sformatf("v%0d_flags", i), bus.out_flags, v_flg[i]);
            if (v_flg[i] != 3'b000)
                check($sformatf("v%0d_ctrl", i), bus.out_ctrl, 0);
            tick();
        end

        // MUL
        drive(1'b1, 32'h70621002, 32'h480);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("mul_flags", bus.out_flags, mul_flags);
        check("mul_md", bus.out_ctrl[CTRL_MD +: 3] != 3'd0, mul_md_nz);
        check("mul_dst", bus.out_dst, mul_dst);
        tick();

        // flush with full queue and input pending
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h00851021, 32'h500);
        tick();
        drive(1'b1, 32'h00851021, 32'h504);
        tick();
        check("fl_full_valid", bus.out_valid, 1);
        drive(1'b1, 32'h00851021, 32'h508);
        flush = 1'b1;
        #1 check("fl_in_ready", bus.in_ready, 0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl_out_valid", bus.out_valid, 0);
        tick();
        check("fl_not_accepted", bus.out_valid, 0);

        // flush with one entry queued
        drive(1'b1, 32'h00851021, 32'h600);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h00851021, 32'h604);
        #1 check("fl1_in_ready", bus.in_ready, 0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        check("fl1_out_valid", bus.out_valid, 0);
        tick();
        check("fl1_not_accepted", bus.out_valid, 0);

        // reset mid-transfer
        drive(1'b1, 32'h00851021, 32'h700);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        check("mr_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("mr_async_valid", bus.out_valid, 0);
        check("mr_async_ready", bus.in_ready, 0);
        #2 rst_n = 1'b1;
        tick();
        check("mr_ready", bus.in_ready, 1);
        check("mr_dropped", bus.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
